sram_like_sim_mem: RTL and testbench
====================================

// Module: sram_like_sim_mem
// PURPOSE
//  Parametrised sram-like slave memory model for CPU-level benches; generalises the fixed-timing instruction/data models.
//  Adds configurable response latency, up to MAX_OUT outstanding in-order requests, LFSR-driven addr_ok back-pressure,
//  byte/half/word write merging with misalignment detection, and a store trace port for the answer-file checker.
//  One instance each sits on the CPU inst and data ports; contents are preloaded through the `mem` array by hierarchy.
// PARAMETERS
//  AW         12        word-address bits; memory depth = 2**AW 32-bit words
//  LATENCY    2         cycles from accept (req&&addr_ok edge) to data_ok for that request; legal 1..15
//  MAX_OUT    4         max accepted-but-unanswered requests; legal 1..16
//  STALL_EN   0         1 = pseudo-random addr_ok throttling enabled
//  LFSR_SEED  16'hACE1  reset value of 16-bit Fibonacci LFSR (taps 16,14,13,11); must be nonzero
// PORTS
//  clk           in   1   clock; all state changes on rising edge
//  rst           in   1   synchronous, active-high reset
//  req           in   1   request valid
//  wr            in   1   1 = write, 0 = read
//  size          in   2   0 = 1B, 1 = 2B, 2 = 4B; 3 illegal
//  addr          in   32  byte address; word index = addr[AW+1:2] (upper bits ignored, wraps)
//  wdata         in   32  write data, already lane-aligned by the master
//  rdata         out  32  full read word, valid only while data_ok
//  addr_ok       out  1   slave can accept this cycle; accept = req && addr_ok
//  data_ok       out  1   response for oldest outstanding request (reads and writes)
//  err_misalign  out  1   1-cycle pulse: accepted request was misaligned or size==3
//  trace_wr      out  1   1-cycle pulse in accept cycle of any write
//  trace_addr    out  32  addr of that write
//  trace_bytes   out  3   1 << size (1,2,4)
//  trace_wdata   out  32  raw wdata of that write
// BEHAVIOUR
//  Reset: addr_ok=0, data_ok=0, rdata=0, err_misalign=0, trace_*=0; queue flushed, count=0, LFSR=LFSR_SEED.
//   mem contents untouched by reset. Reset mid-transaction drops all pending responses; no data_ok after rst.
//  addr_ok (combinational from regs) = !rst && (count < MAX_OUT) && !(STALL_EN && lfsr[0]). Pop in same cycle
//   does NOT free a slot for that cycle's accept (full stays full one cycle).
//  LFSR advances every non-reset cycle regardless of req.
//  Accept: reads sample mem[idx] at the accept edge into the queue entry; writes update mem at the accept edge.
//   Hence in-order read-after-write sees new data, including back-to-back same-address pairs.
//  Write lanes: size0 -> byte lane addr[1:0]; size1 -> half lane addr[1]; size2 -> whole word.
//   Misaligned (size1 & addr[0]; size2 & addr[1:0]!=0) or size==3: request still accepted and answered
//   (data_ok, rdata=0), mem NOT written, err_misalign pulses next cycle; trace_wr still fires.
//  Queue: circular FIFO of MAX_OUT entries {rdata, countdown}; push sets countdown=LATENCY-1;
//   every cycle each valid entry with countdown>0 decrements. data_ok = head valid && head countdown==0;
//   rdata = head data (reads) or 0 (writes); head pops that cycle. Back-to-back data_ok allowed.
//  Simultaneous push+pop: count unchanged, pointers both advance (wrap modulo MAX_OUT).
//  Latency: with addr_ok high, request accepted at edge N gets data_ok high in cycle N+LATENCY (LATENCY=1 -> next cycle).
//  trace_*: registered, valid for one cycle after the accept edge; independent of data_ok.
// TESTING
//  T1 LATENCY=1, STALL_EN=0: read 0x10 with mem[4]=0xDEADBEEF -> data_ok 1 cycle later, rdata=0xDEADBEEF.
//  T2 sb addr=0x21 wdata=0x0000AB00 then lw 0x20 (mem[8]=0x11223344) -> trace bytes=1; rdata=0x1122AB44.
//  T3 MAX_OUT=4, LATENCY=8, req held high with 6 reads -> addr_ok drops after 4 accepts; all 6 data_ok in order.
//  T4 sw addr=0x6 -> err_misalign pulse, data_ok with rdata=0, mem[1] unchanged.
//  T5 rst asserted while 3 requests pending -> no data_ok after rst; first post-reset read returns correct data.
//  T6 STALL_EN=1, 200 random reads/writes vs. reference array -> every response matches, count never > MAX_OUT.

Source files
------------

// File: rtl/sram_like_sim_mem.sv
// Sram-like slave memory model: configurable latency, in-order outstanding queue,
// optional LFSR back-pressure, lane-merged writes with misalignment flagging and a store trace port.
module sram_like_sim_mem #(
   parameter int          AW        = 12,
   parameter int          LATENCY   = 2,
   parameter int          MAX_OUT   = 4,
   parameter int          STALL_EN  = 0,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic        err_misalign,
   output logic        trace_wr,
   output logic [31:0] trace_addr,
   output logic [2:0]  trace_bytes,
   output logic [31:0] trace_wdata
);

   localparam int         DEPTH   = 1 << AW;
   localparam int         PW      = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int         CW      = $clog2(MAX_OUT + 1);
   localparam logic [3:0] CD_INIT = 4'(LATENCY - 1);

   logic [31:0] mem [DEPTH];

   logic [15:0]        lfsr_q, lfsr_d;
   logic [CW-1:0]      count_q, count_d;
   logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
   logic [MAX_OUT-1:0] vld_q, vld_d;
   logic [3:0]         cd_q [MAX_OUT];
   logic [3:0]         cd_d [MAX_OUT];
   logic [31:0]        data_q [MAX_OUT];
   logic [31:0]        data_d [MAX_OUT];

   logic        err_q, err_d;
   logic        twr_q, twr_d;
   logic [31:0] taddr_q, taddr_d;
   logic [2:0]  tbytes_q, tbytes_d;
   logic [31:0] twdata_q, twdata_d;

   logic [AW-1:0] idx;
   logic          misalign;
   logic          accept;
   logic [3:0]    wmask;
   logic          unused_addr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
   endfunction

   assign idx         = addr[AW+1:2];
   assign unused_addr = ^addr[31:AW+2];
   assign misalign    = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
                        (size == 2'd2 && addr[1:0] != 2'b00);

   // Handshake: a request transfers on any cycle where req && addr_ok; the master holds
   // req and its fields stable until then. data_ok answers the oldest accepted request.
   assign addr_ok = !rst && (count_q < CW'(MAX_OUT)) && !((STALL_EN != 0) && lfsr_q[0]);
   assign accept  = req && addr_ok;
   assign data_ok = !rst && vld_q[head_q] && (cd_q[head_q] == 4'd0);
   assign rdata   = data_ok ? data_q[head_q] : 32'd0;

   assign err_misalign = err_q;
   assign trace_wr     = twr_q;
   assign trace_addr   = taddr_q;
   assign trace_bytes  = tbytes_q;
   assign trace_wdata  = twdata_q;

   always_comb begin
      wmask = 4'b0000;
      case (size)
         2'd0:    wmask = 4'b0001 << addr[1:0];
         2'd1:    wmask = addr[1] ? 4'b1100 : 4'b0011;
         2'd2:    wmask = 4'b1111;
         default: wmask = 4'b0000;
      endcase
   end

   always_comb begin
      lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      vld_d    = vld_q;
      cd_d     = cd_q;
      data_d   = data_q;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      err_d    = accept && misalign;
      twr_d    = accept && wr;
      taddr_d  = (accept && wr) ? addr : 32'd0;
      tbytes_d = (accept && wr) ? (3'd1 << size) : 3'd0;
      twdata_d = (accept && wr) ? wdata : 32'd0;

      for (int i = 0; i < MAX_OUT; i++) begin
         if (vld_q[i] && cd_q[i] != 4'd0) cd_d[i] = cd_q[i] - 4'd1;
      end
      if (data_ok) begin
         vld_d[head_q] = 1'b0;
         head_d        = ptr_inc(head_q);
      end
      // Reads capture the word now; a write accepted earlier has already landed in mem.
      if (accept) begin
         vld_d[tail_q]  = 1'b1;
         cd_d[tail_q]   = CD_INIT;
         data_d[tail_q] = (!wr && !misalign) ? mem[idx] : 32'd0;
         tail_d         = ptr_inc(tail_q);
      end
      if (accept && !data_ok)      count_d = count_q + CW'(1);
      else if (!accept && data_ok) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q   <= LFSR_SEED;
         count_q  <= '0;
         head_q   <= '0;
         tail_q   <= '0;
         vld_q    <= '0;
         err_q    <= 1'b0;
         twr_q    <= 1'b0;
         taddr_q  <= 32'd0;
         tbytes_q <= 3'd0;
         twdata_q <= 32'd0;
         for (int i = 0; i < MAX_OUT; i++) begin
            cd_q[i]   <= 4'd0;
            data_q[i] <= 32'd0;
         end
      end else begin
         lfsr_q   <= lfsr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         vld_q    <= vld_d;
         cd_q     <= cd_d;
         data_q   <= data_d;
         err_q    <= err_d;
         twr_q    <= twr_d;
         taddr_q  <= taddr_d;
         tbytes_q <= tbytes_d;
         twdata_q <= twdata_d;
      end
   end

   // Memory contents survive reset so preloaded images stay intact.
   always_ff @(posedge clk) begin
      if (accept && wr && !misalign) begin
         for (int b = 0; b < 4; b++) begin
            if (wmask[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_sram_like_sim_mem.sv
// Bench for sram_like_sim_mem: two instances (1-cycle/1-deep with stall, 8-cycle/4-deep),
// directed scenarios plus random traffic against a time-stamped response-queue model.
module tb_sram_like_sim_mem;

   localparam int          AW    = 6;
   localparam int          WORDS = 1 << AW;
   localparam int          LAT_A = 1, MO_A = 1, ST_A = 1;
   localparam int          LAT_B = 8, MO_B = 4, ST_B = 0;
   localparam logic [15:0] SEED  = 16'hACE1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        req_s [2];
   logic        wr_s [2];
   logic [1:0]  size_s [2];
   logic [31:0] addr_s [2];
   logic [31:0] wdata_s [2];
   logic [31:0] rdata_w [2];
   logic        aok_w [2];
   logic        dok_w [2];
   logic        err_w [2];
   logic        twr_w [2];
   logic [31:0] taddr_w [2];
   logic [2:0]  tbytes_w [2];
   logic [31:0] twdata_w [2];

   sram_like_sim_mem #(.AW(AW), .LATENCY(LAT_A), .MAX_OUT(MO_A), .STALL_EN(ST_A), .LFSR_SEED(SEED)) u_a (
      .clk(clk), .rst(rst), .req(req_s[0]), .wr(wr_s[0]), .size(size_s[0]), .addr(addr_s[0]),
      .wdata(wdata_s[0]), .rdata(rdata_w[0]), .addr_ok(aok_w[0]), .data_ok(dok_w[0]),
      .err_misalign(err_w[0]), .trace_wr(twr_w[0]), .trace_addr(taddr_w[0]),
      .trace_bytes(tbytes_w[0]), .trace_wdata(twdata_w[0]));

   sram_like_sim_mem #(.AW(AW), .LATENCY(LAT_B), .MAX_OUT(MO_B), .STALL_EN(ST_B), .LFSR_SEED(SEED)) u_b (
      .clk(clk), .rst(rst), .req(req_s[1]), .wr(wr_s[1]), .size(size_s[1]), .addr(addr_s[1]),
      .wdata(wdata_s[1]), .rdata(rdata_w[1]), .addr_ok(aok_w[1]), .data_ok(dok_w[1]),
      .err_misalign(err_w[1]), .trace_wr(twr_w[1]), .trace_addr(taddr_w[1]),
      .trace_bytes(tbytes_w[1]), .trace_wdata(twdata_w[1]));

   int checks = 0;
   int errors = 0;

   // Reference model: every accepted request becomes {instance, due cycle, data} in one queue.
   typedef struct {
      int          k;
      int          due;
      logic [31:0] data;
   } resp_t;

   resp_t       mq[$];
   logic [31:0] mm [2][WORDS];
   logic [15:0] lfsr_m [2] = '{SEED, SEED};
   logic        err_m [2] = '{1'b0, 1'b0};
   logic        twr_m [2] = '{1'b0, 1'b0};
   logic [31:0] taddr_m [2] = '{32'd0, 32'd0};
   logic [2:0]  tbytes_m [2] = '{3'd0, 3'd0};
   logic [31:0] twdata_m [2] = '{32'd0, 32'd0};
   int          obs_out [2] = '{0, 0};
   int          dok_cnt [2] = '{0, 0};
   int          cyc = 0;
   bit          chk_en = 1'b0;

   function automatic int lat_of(input int k); return (k == 0) ? LAT_A : LAT_B; endfunction
   function automatic int mo_of(input int k);  return (k == 0) ? MO_A : MO_B;   endfunction
   function automatic bit st_of(input int k);  return (k == 0) ? (ST_A != 0) : (ST_B != 0); endfunction

   function automatic int mcount(input int k);
      int n = 0;
      foreach (mq[i]) if (mq[i].k == k) n++;
      return n;
   endfunction

   function automatic int mfirst(input int k);
      foreach (mq[i]) if (mq[i].k == k) return i;
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            int          n, hi, nb, idx;
            logic        e_aok, e_dok, mis;
            logic [31:0] e_rd, a, d;
            n     = mcount(k);
            hi    = mfirst(k);
            e_aok = !rst && (n < mo_of(k)) && !(st_of(k) && lfsr_m[k][0]);
            e_dok = !rst && (n > 0) && (mq[hi].due == cyc);
            e_rd  = e_dok ? mq[hi].data : 32'd0;
            chk($sformatf("addr_ok[%0d]", k), aok_w[k], e_aok);
            chk($sformatf("data_ok[%0d]", k), dok_w[k], e_dok);
            chk($sformatf("rdata[%0d]", k), rdata_w[k], e_rd);
            chk($sformatf("err_misalign[%0d]", k), err_w[k], err_m[k]);
            chk($sformatf("trace_wr[%0d]", k), twr_w[k], twr_m[k]);
            chk($sformatf("trace_addr[%0d]", k), taddr_w[k], taddr_m[k]);
            chk($sformatf("trace_bytes[%0d]", k), tbytes_w[k], tbytes_m[k]);
            chk($sformatf("trace_wdata[%0d]", k), twdata_w[k], twdata_m[k]);
            chk($sformatf("outstanding_le_max[%0d]", k), 32'(obs_out[k] <= mo_of(k)), 32'd1);
            if (dok_w[k] === 1'b1) dok_cnt[k]++;
            if (rst) obs_out[k] = 0;
            else obs_out[k] = obs_out[k] + int'(req_s[k] && aok_w[k]) - int'(dok_w[k] === 1'b1);

            if (rst) begin
               for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].k == k) mq.delete(i);
               lfsr_m[k] = SEED;
               err_m[k]  = 1'b0;
               twr_m[k]  = 1'b0;
               taddr_m[k] = 32'd0;
               tbytes_m[k] = 3'd0;
               twdata_m[k] = 32'd0;
            end else begin
               lfsr_m[k] = {lfsr_m[k][0] ^ lfsr_m[k][2] ^ lfsr_m[k][3] ^ lfsr_m[k][5], lfsr_m[k][15:1]};
               if (e_dok) mq.delete(hi);
               err_m[k] = 1'b0; twr_m[k] = 1'b0; taddr_m[k] = 32'd0; tbytes_m[k] = 3'd0; twdata_m[k] = 32'd0;
               if (req_s[k] && e_aok) begin
                  a   = addr_s[k];
                  d   = wdata_s[k];
                  nb  = 1 << size_s[k];
                  mis = (size_s[k] == 2'd3) || ((a % nb) != 0);
                  idx = int'((a >> 2) % WORDS);
                  if (wr_s[k] && !mis)
                     for (int b = 0; b < nb; b++) mm[k][idx][(a % 4 + b) * 8 +: 8] = d[(a % 4 + b) * 8 +: 8];
                  mq.push_back('{k: k, due: cyc + lat_of(k), data: (!wr_s[k] && !mis) ? mm[k][idx] : 32'd0});
                  err_m[k] = mis;
                  if (wr_s[k]) begin
                     twr_m[k] = 1'b1; taddr_m[k] = a; tbytes_m[k] = 3'(nb); twdata_m[k] = d;
                  end
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; returns just after the edge that accepted the request.
   task automatic do_req(input int k, input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      int n = 0;
      req_s[k] = 1'b1; wr_s[k] = w; size_s[k] = sz; addr_s[k] = a; wdata_s[k] = d;
      @(negedge clk);
      while (aok_w[k] !== 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (aok_w[k] !== 1'b1) chk($sformatf("accept_timeout[%0d]", k), aok_w[k], 1'b1);
      tick();
   endtask

   task automatic idle(input int k);
      req_s[k] = 1'b0;
   endtask

   task automatic wait_dok(input int k, output logic [31:0] d);
      int n = 0;
      @(negedge clk);
      while (dok_w[k] !== 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (dok_w[k] !== 1'b1) chk($sformatf("data_ok_timeout[%0d]", k), dok_w[k], 1'b1);
      d = rdata_w[k];
   endtask

   task automatic drain(input int k);
      int n = 0;
      while (obs_out[k] != 0 && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk($sformatf("drain[%0d]", k), obs_out[k], 0);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int          base, n;
      logic [1:0]  sz;
      logic [31:0] a;
      for (int k = 0; k < 2; k++) begin
         req_s[k] = 1'b0; wr_s[k] = 1'b0; size_s[k] = 2'd0; addr_s[k] = 32'd0; wdata_s[k] = 32'd0;
      end
      rst = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0;

      // Preload every word of both memories through the port.
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < WORDS; i++) do_req(k, 1'b1, 2'd2, 32'(i * 4), $urandom);
         idle(k);
      end
      drain(0);
      drain(1);

      // T1: one-cycle latency read.
      do_req(0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
      do_req(0, 1'b0, 2'd2, 32'h10, 32'd0);
      idle(0);
      @(negedge clk);
      chk("t1_data_ok", dok_w[0], 1'b1);
      chk("t1_rdata", rdata_w[0], 32'hDEADBEEF);
      tick();

      // T2: byte store merges into an existing word.
      do_req(0, 1'b1, 2'd2, 32'h20, 32'h11223344);
      do_req(0, 1'b1, 2'd0, 32'h21, 32'h0000AB00);
      idle(0);
      @(negedge clk);
      chk("t2_trace_wr", twr_w[0], 1'b1);
      chk("t2_trace_bytes", tbytes_w[0], 3'd1);
      chk("t2_trace_addr", taddr_w[0], 32'h21);
      chk("t2_trace_wdata", twdata_w[0], 32'h0000AB00);
      tick();
      do_req(0, 1'b0, 2'd2, 32'h20, 32'd0);
      idle(0);
      @(negedge clk);
      chk("t2_rdata", rdata_w[0], 32'h1122AB44);
      tick();

      // T4: misaligned word store is answered but leaves memory alone.
      do_req(0, 1'b1, 2'd2, 32'h4, 32'h01020304);
      do_req(0, 1'b1, 2'd2, 32'h6, 32'hFFFFFFFF);
      idle(0);
      @(negedge clk);
      chk("t4_err", err_w[0], 1'b1);
      chk("t4_data_ok", dok_w[0], 1'b1);
      chk("t4_rdata_zero", rdata_w[0], 32'd0);
      chk("t4_trace_wr", twr_w[0], 1'b1);
      tick();
      do_req(0, 1'b0, 2'd2, 32'h4, 32'd0);
      idle(0);
      @(negedge clk);
      chk("t4_mem_unchanged", rdata_w[0], 32'h01020304);
      tick();

      // T3: six reads with req held; the fifth must wait for a free slot.
      base = dok_cnt[1];
      for (int j = 0; j < 6; j++) begin
         do_req(1, 1'b0, 2'd2, 32'(j * 4), 32'd0);
         if (j == 3) begin
            @(negedge clk);
            chk("t3_addr_ok_full", aok_w[1], 1'b0);
            tick();
         end
      end
      idle(1);
      n = 0;
      while (dok_cnt[1] - base < 6 && n < 40) begin
         n++;
         tick();
      end
      chk("t3_response_count", dok_cnt[1] - base, 6);

      // T5: reset with three requests pending.
      do_req(1, 1'b1, 2'd2, 32'h10, 32'hCAFE0123);
      do_req(1, 1'b0, 2'd2, 32'h10, 32'd0);
      do_req(1, 1'b0, 2'd2, 32'h14, 32'd0);
      idle(1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("t5_no_data_ok", dok_w[1], 1'b0);
      end
      tick();
      do_req(1, 1'b0, 2'd2, 32'h10, 32'd0);
      idle(1);
      wait_dok(1, rd);
      chk("t5_rdata", rd, 32'hCAFE0123);
      tick();

      // T6: random mixed traffic on both instances.
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 200; i++) begin
            n  = $urandom_range(0, 9);
            sz = (n == 0) ? 2'd3 : 2'(n % 3);
            a  = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 3) == 0) a = a | 32'h1000_0000;
            do_req(k, 1'($urandom_range(0, 1)), sz, a, $urandom);
            if ($urandom_range(0, 3) == 0) begin
               idle(k);
               tick();
            end
         end
         idle(k);
         drain(k);
      end

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
